// File: rtl/seconds_counter.sv
// MM:SS stopwatch: debounced start/stop button, BCD count, seven-segment outputs.
// The button is synchronized and debounced; each new press toggles run/pause.
module seconds_counter #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CLK_EN,
    input  logic       START_N,
    input  logic       CLR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic       RUN_LED,
    output logic       WRAP
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t      state, state_n;
    logic        sync0, sync1;
    logic        db_level, db_prev;
    logic [CW-1:0] db_cnt;
    logic        press;
    logic        tick;
    logic [3:0]  s1, s10, m1, m10;
    logic [3:0]  s1_n, s10_n, m1_n, m10_n;
    logic        c0, c1, c2, c3;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7f;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync0    <= 1'b1;
            sync1    <= 1'b1;
            db_level <= 1'b1;
            db_prev  <= 1'b1;
            db_cnt   <= '0;
        end else begin
            sync0   <= START_N;
            sync1   <= sync0;
            db_prev <= db_level;
            // Count consecutive disagreeing cycles; any agreement restarts it.
            if (sync1 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
                db_level <= sync1;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press = db_prev & ~db_level;
    assign tick  = (state == RUN) && CLK_EN;

    always_comb begin
        state_n = state;
        if (CLR) begin
            state_n = IDLE;
        end else if (press) begin
            case (state)
                IDLE:    state_n = RUN;
                RUN:     state_n = PAUSE;
                PAUSE:   state_n = RUN;
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        c0    = (s1 == 4'd9);
        c1    = c0 && (s10 == 4'd5);
        c2    = c1 && (m1 == 4'd9);
        c3    = c2 && (m10 == 4'd5);
        s1_n  = c0 ? 4'd0 : s1 + 4'd1;
        s10_n = c0 ? (c1 ? 4'd0 : s10 + 4'd1) : s10;
        m1_n  = c1 ? (c2 ? 4'd0 : m1 + 4'd1) : m1;
        m10_n = c2 ? (c3 ? 4'd0 : m10 + 4'd1) : m10;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            s1    <= '0;
            s10   <= '0;
            m1    <= '0;
            m10   <= '0;
            WRAP  <= 1'b0;
        end else begin
            state <= state_n;
            if (CLR) begin
                s1   <= '0;
                s10  <= '0;
                m1   <= '0;
                m10  <= '0;
                WRAP <= 1'b0;
            end else begin
                WRAP <= tick && c3;
                if (tick) begin
                    s1  <= s1_n;
                    s10 <= s10_n;
                    m1  <= m1_n;
                    m10 <= m10_n;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            HEX0 <= 7'h40;
            HEX1 <= 7'h40;
            HEX2 <= 7'h40;
            HEX3 <= 7'h40;
        end else begin
            HEX0 <= seg(s1);
            HEX1 <= seg(s10);
            HEX2 <= seg(m1);
            HEX3 <= seg(m10);
        end
    end

    assign RUN_LED = (state == RUN);

endmodule

// File: tb/tb_seconds_counter.sv
// Directed bench for seconds_counter with a short debounce window.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_seconds_counter;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CLK_EN = 1'b0;
    logic       START_N = 1'b1;
    logic       CLR = 1'b0;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;
    logic       RUN_LED, WRAP;

    int vectors = 0;
    int errors = 0;

    seconds_counter #(.DEBOUNCE_CYCLES(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .CLK_EN(CLK_EN),
        .START_N(START_N),
        .CLR(CLR),
        .HEX0(HEX0),
        .HEX1(HEX1),
        .HEX2(HEX2),
        .HEX3(HEX3),
        .RUN_LED(RUN_LED),
        .WRAP(WRAP)
    );

    always #10 CLK = ~CLK;

    task automatic chk(input string tag, input logic [6:0] got,
                       input logic [6:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        START_N = 1'b1;
        CLR = 1'b0;
        CLK_EN = 1'b0;
        step();
        RST = 1'b0;
    endtask

    // Hold CLK_EN high for n edges: one increment per edge while running.
    task automatic ticks(input int n);
        CLK_EN = 1'b1;
        repeat (n) step();
        CLK_EN = 1'b0;
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            CLK_EN = 1'b1;
            step();
            CLK_EN = 1'b0;
            step();
        end
    endtask

    // Press lands on the 7th edge after START_N falls (2 sync + 4 debounce + edge detect).
    task automatic press_sync(input logic en, input logic clr);
        START_N = 1'b0;
        repeat (6) step();
        CLK_EN = en;
        CLR = clr;
        step();
        CLK_EN = 1'b0;
        CLR = 1'b0;
    endtask

    task automatic release_btn();
        START_N = 1'b1;
        repeat (10) step();
    endtask

    task automatic chk_hex(input string tag, input logic [6:0] h3,
                           input logic [6:0] h2, input logic [6:0] h1,
                           input logic [6:0] h0);
        chk({tag, "_hex3"}, HEX3, h3);
        chk({tag, "_hex2"}, HEX2, h2);
        chk({tag, "_hex1"}, HEX1, h1);
        chk({tag, "_hex0"}, HEX0, h0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk_hex("rst", 7'h40, 7'h40, 7'h40, 7'h40);
        chk("rst_led", {6'b0, RUN_LED}, 7'd0);
        chk("rst_wrap", {6'b0, WRAP}, 7'd0);

        // Plain 10-cycle press, then 3 pulses -> 00:03
        START_N = 1'b0;
        repeat (10) step();
        START_N = 1'b1;
        chk("p1_led", {6'b0, RUN_LED}, 7'd1);
        repeat (10) step();
        chk("p1_led_held", {6'b0, RUN_LED}, 7'd1);
        pulses(2);
        CLK_EN = 1'b1;
        step();
        CLK_EN = 1'b0;
        chk("p1_hex0_lag", HEX0, 7'h24);
        step();
        chk_hex("p1", 7'h40, 7'h40, 7'h40, 7'h30);

        // IDLE + press + tick -> RUN, tick dropped
        do_reset();
        press_sync(1'b1, 1'b0);
        chk("idle_pt_led", {6'b0, RUN_LED}, 7'd1);
        release_btn();
        chk("idle_pt_hex0", HEX0, 7'h40);

        // Short glitches never reach the debounced level
        do_reset();
        repeat (3) begin
            START_N = 1'b0;
            repeat (2) step();
            START_N = 1'b1;
            repeat (2) step();
        end
        repeat (10) step();
        chk("glitch_led", {6'b0, RUN_LED}, 7'd0);
        pulses(3);
        chk("glitch_hex0", HEX0, 7'h40);

        // Count to 59:59, then one tick wraps
        do_reset();
        press_sync(1'b0, 1'b0);
        release_btn();
        ticks(3599);
        step();
        chk_hex("5959", 7'h12, 7'h10, 7'h12, 7'h10);
        chk("pre_wrap", {6'b0, WRAP}, 7'd0);
        CLK_EN = 1'b1;
        step();
        CLK_EN = 1'b0;
        chk("wrap_hi", {6'b0, WRAP}, 7'd1);
        step();
        chk("wrap_lo", {6'b0, WRAP}, 7'd0);
        chk_hex("wrap", 7'h40, 7'h40, 7'h40, 7'h40);
        step();
        chk("wrap_lo2", {6'b0, WRAP}, 7'd0);

        // RUN at 00:07: press with tick -> 00:08 PAUSE
        do_reset();
        press_sync(1'b0, 1'b0);
        release_btn();
        ticks(7);
        press_sync(1'b1, 1'b0);
        chk("pause_led", {6'b0, RUN_LED}, 7'd0);
        release_btn();
        chk_hex("p08", 7'h40, 7'h40, 7'h40, 7'h00);
        pulses(5);
        chk("pause_hold_hex0", HEX0, 7'h00);
        chk("pause_hold_led", {6'b0, RUN_LED}, 7'd0);
        press_sync(1'b1, 1'b0);
        chk("resume_led", {6'b0, RUN_LED}, 7'd1);
        release_btn();
        chk("resume_hex0", HEX0, 7'h00);
        pulses(1);
        chk("resume_tick", HEX0, 7'h10);

        // CLR beats press and tick at 12:34
        do_reset();
        press_sync(1'b0, 1'b0);
        release_btn();
        ticks(754);
        step();
        chk_hex("1234", 7'h79, 7'h24, 7'h30, 7'h19);
        press_sync(1'b1, 1'b1);
        chk("clr_led", {6'b0, RUN_LED}, 7'd0);
        chk("clr_wrap", {6'b0, WRAP}, 7'd0);
        release_btn();
        chk_hex("clr", 7'h40, 7'h40, 7'h40, 7'h40);
        pulses(2);
        chk("clr_idle_hex0", HEX0, 7'h40);

        // RST at 05:09 mid-debounce discards everything
        do_reset();
        press_sync(1'b0, 1'b0);
        release_btn();
        ticks(309);
        step();
        chk_hex("0509", 7'h40, 7'h12, 7'h40, 7'h10);
        START_N = 1'b0;
        repeat (4) step();
        RST = 1'b1;
        START_N = 1'b1;
        step();
        chk_hex("rst2", 7'h40, 7'h40, 7'h40, 7'h40);
        chk("rst2_led", {6'b0, RUN_LED}, 7'd0);
        chk("rst2_wrap", {6'b0, WRAP}, 7'd0);
        RST = 1'b0;
        repeat (12) step();
        chk("rst2_nopress", {6'b0, RUN_LED}, 7'd0);
        pulses(2);
        chk("rst2_hex0", HEX0, 7'h40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
